boreal_replay_dump_ctrl: RTL and testbench

//   Host-side extraction engine downstream of the 1024x48 replay ledger. On a start pulse it

---
 rtl/boreal_replay_dump_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_boreal_replay_dump_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_replay_dump_ctrl.sv
// -----------------------------------------------------------------------------
// boreal_replay_dump_ctrl
//
// Host-side extraction engine for the replay ledger. On an accepted start it
// walks a range of ledger entries through the ledger's 1-cycle-latency read
// port. It emits them as a framed byte stream over a valid/ready handshake:
//
//   SYNC_BYTE, count_hi, count_lo, 6 bytes per entry (MSB first), checksum
//
// The checksum is the XOR of every byte after SYNC.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        1-cycle dump request, only looked at while idle
//   start_addr   first ledger address of the dump (sampled with start)
//   entry_count  number of entries, 0 ignored, >1024 clamped (sampled with start)
//   abort        cancels the frame in progress
//   rd_addr      registered ledger read address
//   rd_data      ledger read data {mu_t, epsilon, hrv_metric}, valid 1 cycle
//                after rd_addr
//   tx_data      byte to the host transmitter
//   tx_valid     tx_data valid
//   tx_ready     transmitter accepts the byte (transfer = tx_valid & tx_ready)
//   busy         a frame is in progress
//   done         1-cycle pulse after the checksum byte has transferred
//   aborted      1-cycle pulse after a frame was cancelled by abort
// -----------------------------------------------------------------------------
module boreal_replay_dump_ctrl #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [10:0]       entry_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [47:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_CSUM
  } state_t;

  localparam logic [10:0] MAX_COUNT = 11'd1024;

  state_t            state;
  state_t            state_nxt;

  logic [2:0]        byte_idx;   // byte position inside header (0..2) or entry (0..5)
  logic [10:0]       count_q;    // clamped entry count, reported in the header
  logic [10:0]       remain_q;   // entries still to be sent
  logic [ADDR_W-1:0] addr_q;     // address of the entry being fetched/sent
  logic              done_q;
  logic              aborted_q;

  logic [47:0]       shreg;      // entry being sent, current byte in [47:40]
  logic [7:0]        csum;

  logic              accept;
  logic              xfer;
  logic              hdr_last;
  logic              send_last;
  logic              cancel;

  // The header carries the clamped count, so clamping happens once at accept.
  function automatic logic [10:0] sat_count(input logic [10:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

  // Address wraps modulo the ledger depth, so a full-depth dump starting
  // anywhere visits every address exactly once.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign accept    = (state == S_IDLE) && start && !abort && (entry_count != 11'd0);
  assign cancel    = (state != S_IDLE) && abort;
  assign xfer      = tx_valid && tx_ready;
  assign hdr_last  = (byte_idx == 3'd2);
  assign send_last = (byte_idx == 3'd5);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Abort overrides everything, including a transfer that
  // would otherwise complete in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer && hdr_last) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (xfer && send_last) begin
          // remain_q is decremented on this same edge; 1 means this was the last entry
          state_nxt = (remain_q == 11'd1) ? S_CSUM : S_FETCH;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (cancel) begin
      state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only: tx_valid never depends on
  // tx_ready, and tx_data cannot change while a byte is stalled because
  // none of its sources move without a transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_HDR: begin
        tx_valid = 1'b1;
        case (byte_idx)
          3'd0:    tx_data = SYNC_BYTE;
          3'd1:    tx_data = {5'b0, count_q[10:8]};
          default: tx_data = count_q[7:0];
        endcase
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[47:40];
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign rd_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Frame control: byte position, entry counters, read address, pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx  <= 3'd0;
      count_q   <= 11'd0;
      remain_q  <= 11'd0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (cancel) begin
        aborted_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              count_q  <= sat_count(entry_count);
              remain_q <= sat_count(entry_count);
              addr_q   <= start_addr;
              byte_idx <= 3'd0;
            end
          end
          S_HDR: begin
            if (xfer) begin
              byte_idx <= hdr_last ? 3'd0 : byte_idx + 3'd1;
            end
          end
          S_SEND: begin
            if (xfer) begin
              if (send_last) begin
                byte_idx <= 3'd0;
                remain_q <= remain_q - 11'd1;
                addr_q   <= next_addr(addr_q);
              end else begin
                byte_idx <= byte_idx + 3'd1;
              end
            end
          end
          S_CSUM: begin
            if (xfer) begin
              done_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: entry shift register and running checksum (no reset needed;
  // the checksum restarts on every accepted start, the shift register is
  // loaded before it is ever sent).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      csum <= 8'h00;
    end else if (xfer && ((state == S_HDR && byte_idx != 3'd0) || state == S_SEND)) begin
      csum <= csum ^ tx_data;
    end

    // rd_data answers the address presented during FETCH, so it is valid in LATCH
    if (state == S_LATCH) begin
      shreg <= rd_data;
    end else if (state == S_SEND && xfer) begin
      shreg <= {shreg[39:0], 8'h00};
    end
  end

endmodule

// File: tb/tb_boreal_replay_dump_ctrl.sv
module tb_boreal_replay_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] entry_count = '0;
  logic        abort = 1'b0;
  logic [9:0]  rd_addr;
  logic [47:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        aborted;

  boreal_replay_dump_ctrl #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .entry_count(entry_count), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Ledger model: 1-cycle read latency
  logic [47:0] mem [0:1023];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready generator: 0 = always ready, 1 = random, 2 = 10-cycle stall mid entry then random
  int rmode = 0;
  int stall_cnt = 0;
  logic [7:0] cap [$];
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: tx_ready = 1'($urandom_range(0, 1));
      2: begin
        if (cap.size() >= 5 && stall_cnt < 10) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
      default: begin
        tx_ready = 1'b1;
        stall_cnt = 0;
      end
    endcase
  end

  // Monitor, sampled on the falling edge
  int   addr_seen [$];
  int   done_cnt = 0, abort_cnt = 0, busy_cnt = 0, stall_viol = 0;
  logic prev_stall = 1'b0, prev_fetch = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && !abort && !(tx_valid && tx_data == prev_data)) stall_viol++;
      if (tx_valid && tx_ready && !abort) cap.push_back(tx_data);
      if (busy && !tx_valid && !prev_fetch) addr_seen.push_back(int'(rd_addr));
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (busy) busy_cnt++;
    end
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_fetch = rst_n && busy && !tx_valid;
    prev_data  = tx_data;
  end

  // Reference model: the whole expected frame built from the ledger contents
  logic [7:0] exp_q [$];
  int         exp_addr [$];
  task automatic build_exp(input int sa, input int cnt);
    int n;
    logic [7:0] x;
    logic [7:0] b;
    logic [47:0] e;
    n = (cnt > 1024) ? 1024 : cnt;
    exp_q.delete();
    exp_addr.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n / 256));
    exp_q.push_back(8'(n % 256));
    x = 8'(n / 256) ^ 8'(n % 256);
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back((sa + k) % 1024);
      e = mem[(sa + k) % 1024];
      for (int j = 0; j < 6; j++) begin
        b = e[47 - 8*j -: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic pulse_start(input int sa, input int cnt, input logic ab);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 10'(sa); entry_count = 11'(cnt); abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_frame(input int sa, input int cnt, input int rm, input int restart);
    logic seen;
    int mism;
    int first;
    cap.delete(); addr_seen.delete();
    done_cnt = 0; abort_cnt = 0; stall_viol = 0;
    rmode = rm;
    build_exp(sa, cnt);
    pulse_start(sa, cnt, 1'b0);
    if (restart > 0) begin
      repeat (restart) @(posedge clk);
      #1;
      start = 1'b1; start_addr = 10'd100; entry_count = 11'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("stall_stable", stall_viol, 0);
    rmode = 0;
    chk("frame_len", cap.size(), exp_q.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      if (cap[i] !== exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    if (mism != 0) $display("first byte difference at index %0d", first);
    chk("frame_bytes", mism, 0);
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < addr_seen.size(); i++)
      if (addr_seen[i] != exp_addr[i]) mism++;
    chk("addr_count", addr_seen.size(), exp_addr.size());
    chk("addr_seq", mism, 0);
  endtask

  typedef struct {
    int sa; int cnt; int rm; int restart;
    int exp_len; logic [7:0] exp_hi; logic [7:0] exp_lo;
  } vec_t;

  vec_t vecs [7];
  logic [7:0] t1 [16];

  initial begin
    vecs[0] = '{sa: 5,    cnt: 2,    rm: 0, restart: -1, exp_len: 16,   exp_hi: 8'h00, exp_lo: 8'h02};
    vecs[1] = '{sa: 1022, cnt: 4,    rm: 0, restart: -1, exp_len: 28,   exp_hi: 8'h00, exp_lo: 8'h04};
    vecs[2] = '{sa: 5,    cnt: 2,    rm: 2, restart: -1, exp_len: 16,   exp_hi: 8'h00, exp_lo: 8'h02};
    vecs[3] = '{sa: 5,    cnt: 2,    rm: 1, restart: 4,  exp_len: 16,   exp_hi: 8'h00, exp_lo: 8'h02};
    vecs[4] = '{sa: 7,    cnt: 1500, rm: 0, restart: -1, exp_len: 6148, exp_hi: 8'h04, exp_lo: 8'h00};
    vecs[5] = '{sa: 300,  cnt: 1024, rm: 1, restart: -1, exp_len: 6148, exp_hi: 8'h04, exp_lo: 8'h00};
    vecs[6] = '{sa: 1023, cnt: 1,    rm: 0, restart: -1, exp_len: 10,   exp_hi: 8'h00, exp_lo: 8'h01};
    t1 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h05, 8'hFF, 8'hFA, 8'h5A, 8'h5F,
           8'h00, 8'h06, 8'hFF, 8'hF9, 8'h5A, 8'h5C, 8'h01};

    for (int k = 0; k < 1024; k++)
      mem[k] = {16'(k), ~16'(k), 16'(k) ^ 16'h5A5A};

    // Reset state
    #12;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_rd_addr", rd_addr, 10'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].sa, vecs[i].cnt, vecs[i].rm, vecs[i].restart);
      chk("tbl_len", cap.size(), vecs[i].exp_len);
      chk("tbl_sync", (cap.size() > 0) ? cap[0] : 8'hxx, 8'hA5);
      chk("tbl_hi", (cap.size() > 1) ? cap[1] : 8'hxx, vecs[i].exp_hi);
      chk("tbl_lo", (cap.size() > 2) ? cap[2] : 8'hxx, vecs[i].exp_lo);
      if (i == 0) begin
        for (int j = 0; j < 16; j++)
          chk("t1_literal", (cap.size() > j) ? cap[j] : 8'hxx, t1[j]);
      end
    end

    // count = 0 is ignored
    busy_cnt = 0; cap.delete();
    pulse_start(5, 0, 1'b0);
    repeat (20) @(negedge clk);
    chk("cnt0_busy", busy_cnt, 0);
    chk("cnt0_bytes", cap.size(), 0);

    // start together with abort while idle is ignored
    busy_cnt = 0; abort_cnt = 0;
    pulse_start(5, 2, 1'b1);
    repeat (10) @(negedge clk);
    chk("start_abort_busy", busy_cnt, 0);
    chk("start_abort_pulse", abort_cnt, 0);

    // Abort while the 3rd byte of entry 2 is presented
    cap.delete(); done_cnt = 0; abort_cnt = 0; rmode = 0;
    pulse_start(5, 2, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (cap.size() >= 11) break;
    end
    chk("abort_pos", cap.size(), 11);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_tx_valid", tx_valid, 1'b0);
    chk("abort_pulse", aborted, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("abort_pulse_len", aborted, 1'b0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_count", abort_cnt, 1);
    chk("abort_no_more_bytes", cap.size(), 11);
    run_frame(5, 2, 0, -1);
    chk("after_abort_sync", (cap.size() > 0) ? cap[0] : 8'hxx, 8'hA5);

    // Reset in the middle of SEND
    cap.delete(); rmode = 0;
    pulse_start(5, 2, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (cap.size() >= 5) break;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {tx_valid, busy, done, aborted, tx_data, rd_addr}, 22'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_more_bytes", cap.size(), 5);
    chk("midrst_idle", busy, 1'b0);
    run_frame(1022, 4, 0, -1);

    // Randomized ledger contents and frames against the model
    for (int k = 0; k < 1024; k++)
      mem[k] = {16'($urandom), 32'($urandom)};
    for (int r = 0; r < 6; r++)
      run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)),
                int'($urandom_range(0, 2)), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
